// File: rtl/scaler_pkg.sv
// scaler_pkg: shared widths, constants, FSM states and K saturation helper for the scaler K sequencer
package scaler_pkg;
  localparam int DIM_W = 12;
  localparam int QUO_W = 20;
  localparam int K_W = 16;
  localparam int K_FRAC_BITS = 8;
  localparam logic [K_W-1:0] K_SAT = 16'hFFFF;
  typedef enum logic [2:0] {IDLE, LOAD_H, WAIT_H, LOAD_V, WAIT_V, DONE} k_state_e;
  // zero denominator or a quotient that does not fit 8.8 both saturate K
  function automatic logic [K_W-1:0] k_sat(input logic [DIM_W-1:0] den, input logic [QUO_W-1:0] q);
    return (den == '0 || q[QUO_W-1:K_W] != '0) ? K_SAT : q[K_W-1:0];
  endfunction
endpackage

// File: rtl/scaler_k_sched.sv
// scaler_k_sched: drives one shared pipelined divider to produce an atomic pair of 8.8 scale factors
//   start, s_width/s_height/t_width/t_height : recompute request, live source/target dimensions
//   div_numer, div_denom, div_quotient       : operands to and result from the external divider
//   h_scale_K, v_scale_K, k_valid, k_done    : registered K pair, ever-computed flag, update pulse
//   busy, div_err, ovf_err                   : sequencer activity, last-run error flags
module scaler_k_sched
  import scaler_pkg::*;
#(
  parameter int DIV_LATENCY = 20,
  parameter bit AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] s_width,
  input  logic [DIM_W-1:0] s_height,
  input  logic [DIM_W-1:0] t_width,
  input  logic [DIM_W-1:0] t_height,
  output logic [QUO_W-1:0] div_numer,
  output logic [DIM_W-1:0] div_denom,
  input  logic [QUO_W-1:0] div_quotient,
  output logic [K_W-1:0]   h_scale_K,
  output logic [K_W-1:0]   v_scale_K,
  output logic             k_valid,
  output logic             k_done,
  output logic             busy,
  output logic             div_err,
  output logic             ovf_err
);
  k_state_e state, nxt;
  logic [7:0] cnt;
  logic pend;
  logic [DIM_W-1:0] snap_sw, snap_sh, snap_tw, snap_th;
  logic [K_W-1:0] h_k, v_k;
  logic h_de, h_oe, v_de, v_oe;
  logic trig, cnt_zero, cap_h, cap_v;
  assign trig = start | (AUTO_START & ({s_width, s_height, t_width, t_height} != {snap_sw, snap_sh, snap_tw, snap_th}));
  assign cnt_zero = cnt == 8'd0;
  assign cap_h = state == WAIT_H && cnt_zero;
  assign cap_v = state == WAIT_V && cnt_zero;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = trig ? LOAD_H : IDLE;
      LOAD_H:  nxt = WAIT_H;
      WAIT_H:  nxt = cnt_zero ? LOAD_V : WAIT_H;
      LOAD_V:  nxt = WAIT_V;
      WAIT_V:  nxt = cnt_zero ? DONE : WAIT_V;
      DONE:    nxt = (trig | pend) ? LOAD_H : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // operands are registered on entry to LOAD_x so they are already stable in the LOAD_x cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pend <= 1'b0;
      {snap_sw, snap_sh, snap_tw, snap_th} <= '0;
      div_numer <= '0;
      div_denom <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == LOAD_H || state == LOAD_V) ? 8'(DIV_LATENCY - 1) : cnt_zero ? cnt : cnt - 8'd1;
      if (nxt == LOAD_H) begin
        {snap_sw, snap_sh, snap_tw, snap_th} <= {s_width, s_height, t_width, t_height};
        div_numer <= {s_width, {K_FRAC_BITS{1'b0}}};
        div_denom <= t_width;
        pend <= 1'b0;
      end else if (trig && busy) pend <= 1'b1;
      if (nxt == LOAD_V) begin
        div_numer <= {snap_sh, {K_FRAC_BITS{1'b0}}};
        div_denom <= snap_th;
      end
    end
  // per-axis results stage here and only reach the outputs together in DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {h_k, v_k, h_de, h_oe, v_de, v_oe} <= '0;
      {h_scale_K, v_scale_K} <= '0;
      {k_valid, k_done, div_err, ovf_err} <= '0;
    end else begin
      if (cap_h) begin
        h_k <= k_sat(snap_tw, div_quotient);
        h_de <= snap_tw == '0;
        h_oe <= snap_tw != '0 && div_quotient[QUO_W-1:K_W] != '0;
      end
      if (cap_v) begin
        v_k <= k_sat(snap_th, div_quotient);
        v_de <= snap_th == '0;
        v_oe <= snap_th != '0 && div_quotient[QUO_W-1:K_W] != '0;
      end
      k_done <= state == DONE;
      if (state == DONE) begin
        h_scale_K <= h_k;
        v_scale_K <= v_k;
        div_err <= h_de | v_de;
        ovf_err <= h_oe | v_oe;
        k_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_scaler_k_sched.sv
// tb_scaler_k_sched: directed bench with a run-level reference model and a behavioural L-cycle divider
module tb_scaler_k_sched;
  localparam int L = 20;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [11:0] s_width = '0, s_height = '0, t_width = '0, t_height = '0;
  logic [19:0] div_numer, div_quotient;
  logic [11:0] div_denom;
  logic [15:0] h_scale_K, v_scale_K;
  logic k_valid, k_done, busy, div_err, ovf_err;
  scaler_k_sched #(.DIV_LATENCY(L), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_width(s_width), .s_height(s_height), .t_width(t_width), .t_height(t_height),
    .div_numer(div_numer), .div_denom(div_denom), .div_quotient(div_quotient),
    .h_scale_K(h_scale_K), .v_scale_K(v_scale_K),
    .k_valid(k_valid), .k_done(k_done), .busy(busy), .div_err(div_err), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  logic [19:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= (div_denom == 12'd0) ? 20'hABCDE : div_numer / 20'(div_denom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign div_quotient = pipe[L-1];
  function automatic logic [15:0] kval(input int s, input int t, output bit de, output bit oe);
    int q;
    de = t == 0;
    oe = 1'b0;
    if (de) return 16'hFFFF;
    q = s * 256 / t;
    oe = q > 65535;
    return oe ? 16'hFFFF : 16'(q);
  endfunction
  logic [47:0] live, snap = '0;
  assign live = {s_width, s_height, t_width, t_height};
  bit run_on = 0, pend = 0;
  int cyc = 0, t_done = 0;
  logic [15:0] r_h = '0, r_v = '0, exp_h = '0, exp_v = '0;
  bit r_de = 0, r_oe = 0, exp_de = 0, exp_oe = 0, exp_valid = 0, exp_done = 0;
  always @(posedge clk or negedge rst_n) begin : model
    bit trg, fin, hd, vd, ho, vo;
    logic [15:0] kh, kv;
    if (!rst_n) begin
      run_on <= 0; pend <= 0; cyc <= 0; snap <= '0;
      exp_h <= '0; exp_v <= '0; exp_de <= 0; exp_oe <= 0; exp_valid <= 0; exp_done <= 0;
    end else begin
      fin = run_on && cyc == t_done;
      trg = start || live != snap || (fin && pend);
      kh = kval(int'(s_width), int'(t_width), hd, ho);
      kv = kval(int'(s_height), int'(t_height), vd, vo);
      exp_done <= fin;
      if (fin) begin
        exp_h <= r_h; exp_v <= r_v; exp_de <= r_de; exp_oe <= r_oe; exp_valid <= 1;
      end
      if (run_on && !fin) pend <= pend || trg;
      else if (trg) begin
        run_on <= 1; t_done <= cyc + 3 + 2 * L; snap <= live; pend <= 0;
        r_h <= kh; r_v <= kv; r_de <= hd | vd; r_oe <= ho | vo;
      end else run_on <= 0;
      cyc <= cyc + 1;
    end
  end
  int tests = 0, fails = 0, pin_seq = 0, pin_seen = 0, ndone = 0;
  string pin_name = "";
  logic [31:0] pin_act = '0, pin_exp = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(run_on));
    chk("k_done", 32'(k_done), 32'(exp_done));
    chk("k_valid", 32'(k_valid), 32'(exp_valid));
    chk("h_scale_K", 32'(h_scale_K), 32'(exp_h));
    chk("v_scale_K", 32'(v_scale_K), 32'(exp_v));
    chk("div_err", 32'(div_err), 32'(exp_de));
    chk("ovf_err", 32'(ovf_err), 32'(exp_oe));
    if (pin_seq != pin_seen) begin
      pin_seen = pin_seq;
      chk(pin_name, pin_act, pin_exp);
    end
  end
  always @(negedge clk) if (rst_n && k_done) ndone <= ndone + 1;
  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    pin_name = name; pin_act = act; pin_exp = exp; pin_seq++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
    s_width = a; s_height = b; t_width = c; t_height = d;
  endtask
  task automatic run(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] d,
                     input logic st, output int n);
    set_in(a, b, c, d);
    start = st;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (k_done) break;
      @(posedge clk);
      #1 n++;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, d0;
    repeat (3) @(posedge clk);
    #1;
    pin("rst_numer", 32'(div_numer), 0);
    pin("rst_h", 32'(h_scale_K), 0);
    pin("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run(1920, 1080, 1280, 720, 1, n);
    pin("latency", n, 44);
    pin("hd_h", 32'(h_scale_K), 32'h0180);
    pin("hd_v", 32'(v_scale_K), 32'h0180);
    pin("hd_valid", 32'(k_valid), 1);
    run(1920, 1080, 1280, 720, 1, n);
    pin("latency_start_only", n, 44);
    run(1920, 1080, 0, 540, 1, n);
    pin("z_h", 32'(h_scale_K), 32'hFFFF);
    pin("z_v", 32'(v_scale_K), 32'h0200);
    pin("z_div_err", 32'(div_err), 1);
    pin("z_ovf_err", 32'(ovf_err), 0);
    run(4095, 1080, 1, 540, 1, n);
    pin("o_h", 32'(h_scale_K), 32'hFFFF);
    pin("o_ovf_err", 32'(ovf_err), 1);
    pin("o_div_err", 32'(div_err), 0);
    run(640, 1080, 1280, 540, 1, n);
    pin("u_h", 32'(h_scale_K), 32'h0080);
    pin("u_flags", 32'({div_err, ovf_err}), 0);
    d0 = ndone;
    set_in(1920, 1080, 1280, 720);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 set_in(640, 480, 1280, 960);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 set_in(1280, 720, 1280, 720);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    pin("coalesce_dones", 32'(ndone - d0), 2);
    pin("rerun_h", 32'(h_scale_K), 32'h0100);
    pin("rerun_v", 32'(v_scale_K), 32'h0100);
    run(1920, 1080, 1280, 720, 1, n);
    run(1920, 1080, 1280, 1080, 0, n);
    pin("auto_latency", n, 44);
    pin("auto_v", 32'(v_scale_K), 32'h0100);
    pin("auto_h", 32'(h_scale_K), 32'h0180);
    set_in(1920, 1080, 1280, 720);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    #1;
    pin("mid_rst_all", 32'({h_scale_K, v_scale_K} | 32'({k_valid, k_done, busy, div_err, ovf_err})), 0);
    pin("mid_rst_ops", 32'({div_numer, div_denom}), 0);
    rst_n = 1'b1;
    d0 = ndone;
    repeat (100) @(posedge clk);
    #1;
    pin("post_rst_valid", 32'(k_valid), 0);
    pin("post_rst_busy", 32'(busy), 0);
    pin("post_rst_dones", 32'(ndone - d0), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scaler_k_sched.md
# scaler_k_sched

Sequencer that computes the horizontal and vertical scale factors (K = source·256 / target, 8.8 fixed point) for the video scaler using one shared pipelined `divider` instance instead of two. It snapshots the source and target dimensions and issues the two divisions back to back. Both results are updated atomically with saturation and error flags, and a one-cycle done pulse tells the scaler line/pixel engines when new K values apply. It sits between the video-mode configuration registers and the scaler datapath.

## Interface
- `DIV_LATENCY`, 20: divider pipeline depth in cycles, from operands applied to quotient valid; legal range 1..255.
- `AUTO_START`, 1: when 1, any change of the four dimension inputs starts a computation, in addition to `start`.
- `clk` input 1: single clock domain for the block and the divider.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to recompute.
- `s_width`, `s_height`, `t_width`, `t_height` input 12 each: source and target dimensions.
- `div_numer` output 20: divider numerator, `{s_dim, 8'd0}`.
- `div_denom` output 12: divider denominator, the target dimension.
- `div_quotient` input 20: divider quotient.
- `h_scale_K`, `v_scale_K` output 16: registered 8.8 scale factors.
- `k_valid` output 1: high once at least one computation has completed.
- `k_done` output 1: one-cycle pulse when the K outputs update.
- `busy` output 1: high in every state except IDLE.
- `div_err` output 1: a target dimension was zero in the last computation.
- `ovf_err` output 1: a quotient exceeded 16 bits in the last computation.

## Operation
- FSM states: IDLE, LOAD_H, WAIT_H, LOAD_V, WAIT_V, DONE.
- Transitions:
  - IDLE→LOAD_H on a trigger; the four dimensions are snapshotted in the same cycle.
  - LOAD_H→WAIT_H.
  - WAIT_H→LOAD_V when the wait counter expires.
  - LOAD_V→WAIT_V.
  - WAIT_V→DONE when the counter expires.
  - DONE→IDLE, or DONE→LOAD_H if a request is pending.
- Trigger: a `start` pulse, or, when AUTO_START=1, a mismatch between the live inputs and the last snapshot.
- Operand drive:
  - From LOAD_H through WAIT_H: `div_numer={snap_s_width,8'd0}`, `div_denom=snap_t_width`.
  - From LOAD_V through WAIT_V: the height operands.
  - In IDLE and DONE: operands hold their last value.
- Capture: the quotient is sampled on the last WAIT_x cycle, DIV_LATENCY cycles after the LOAD_x cycle. An 8-bit down-counter is loaded with DIV_LATENCY−1 in LOAD_x.
- Per-axis result rules:
  - Denominator == 0: K=16'hFFFF and `div_err` set. The divider output is ignored.
  - Otherwise, quotient[19:16]≠0: K=16'hFFFF and `ovf_err` set.
  - Otherwise: K=quotient[15:0].
- Atomic update: h/v results are held in staging registers. `h_scale_K`, `v_scale_K`, `div_err`, `ovf_err` and `k_valid` load only in DONE, so the scaler never sees a mixed pair.
- A trigger while busy sets a single pending flag. Multiple triggers coalesce into one flag. The flag is cleared when the FSM next enters LOAD_H, and that run re-snapshots the inputs at that point.
- Simultaneous trigger and DONE: the FSM goes straight to LOAD_H; `k_done` still pulses for the finished run.
- Reset, including mid-operation:
  - FSM returns to IDLE; pending and counter are cleared.
  - All outputs go to 0: K=0, `k_valid`=0, `k_done`=0, `busy`=0, both error flags 0, divider operands 0.
  - The snapshot registers clear to 0. With AUTO_START=1, any nonzero input therefore triggers a run right after reset.

## Timing
- Cycle 0: trigger sampled in IDLE.
- Cycle 1: LOAD_H.
- Cycle 1+L: h quotient captured.
- Cycle 2+L: LOAD_V.
- Cycle 2+2L: v quotient captured.
- Cycle 3+2L: DONE.
- Cycle 4+2L: outputs and `k_done` visible, 2L+4 cycles after the trigger. With L=20 this is cycle 44.
- `busy` is high from cycle 1 through 3+2L inclusive.
- The minimum spacing between two `k_done` pulses is 2L+3 cycles.

## Structure
- Shared package `scaler_pkg`:
  - FSM state enum.
  - `K_FRAC_BITS=8`.
  - `K_SAT=16'hFFFF`.
  - Dimension width 12 and quotient width 20.
- No sub-module inside the block. The `divider` stays an external sibling instance, wired in `scaler_K_gen`'s replacement wrapper, so vendor divider selection remains outside this block.

## Test plan
- Reset, then `start` with 1920×1080→1280×720 and a behavioural divider of L=20 → `k_done` at cycle 44; `h_scale_K`=`v_scale_K`=16'h0180; `k_valid`=1; no error flags.
- `t_width`=0, `t_height`=540, source 1920×1080 → `h_scale_K`=16'hFFFF, `v_scale_K`=16'h0200, `div_err`=1, `ovf_err`=0.
- `s_width`=4095, `t_width`=1 → `h_scale_K`=16'hFFFF, `ovf_err`=1. Then 640→1280 → `h_scale_K`=16'h0080 and both flags clear.
- Three `start` pulses during one busy run, with inputs changed between them → exactly two `k_done` pulses. The second result reflects the inputs at the rerun's LOAD_H cycle.
- AUTO_START=1 with `t_height` changed 720→1080 while idle → one run starts without `start`; `v_scale_K`=16'h0100.
- Assert `rst_n` low during WAIT_V → all outputs 0 immediately. After release with no inputs applied (all zero), no run starts and `k_valid` stays 0.
